fifo_level_monitor: RTL and testbench
=====================================

FIFO_LEVEL_MONITOR -- requirements
Module: fifo_level_monitor

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DEPTH, default 8, SHALL set the capacity of each of the four tracked FIFOs in entries.
REQ-003 Parameter CW, default 4, SHALL set the occupancy counter width; CW SHALL satisfy 2^CW > DEPTH.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 reset_L  in  1  synchronous active-low reset.
REQ-006 set_init  in  1  configuration window; thresholds are sampled while it is high.
REQ-007 thr_high  in  CW  pause watermark, common to all four FIFOs.
REQ-008 thr_low  in  CW  resume watermark, common to all four FIFOs.
REQ-009 push  in  4  per-FIFO write strobe, bit i = FIFO i.
REQ-010 pop  in  4  per-FIFO read strobe.
REQ-011 occupancy  out  4*CW  per-FIFO count; FIFO i occupies bits [i*CW +: CW].
REQ-012 empty  out  4  count==0.
REQ-013 full  out  4  count==DEPTH.
REQ-014 pause_fifos  out  4  level: FIFO i is in PAUSED state.
REQ-015 continue_fifos  out  4  one-cycle pulse on the PAUSED->RUN transition of FIFO i.
REQ-016 err_ovf  out  4  sticky: push was received while FIFO i was full and not popped.
REQ-017 err_udf  out  4  sticky: pop was received while FIFO i was empty.
REQ-018 cfg_err  out  1  the last set_init sample was rejected.

Function
REQ-019 Counters SHALL update on the rising CLK edge after the strobes; empty and full SHALL decode combinationally from the registered counts.
REQ-020 push only SHALL increment the count when count<DEPTH; otherwise the count holds and err_ovf[i] is set.
REQ-021 pop only SHALL decrement the count when count>0; otherwise the count holds and err_udf[i] is set.
REQ-022 push and pop together with 0<count<=DEPTH SHALL leave the count unchanged with no error.
REQ-023 push and pop together with count==0 SHALL set count=1 and set err_udf[i].
REQ-024 Each FIFO SHALL have an independent two-state hysteresis FSM, RUN/PAUSED, evaluated on its registered count.
REQ-025 RUN->PAUSED SHALL occur when count>=thr_high_r; pause_fifos[i] rises one cycle after the count reaches the threshold.
REQ-026 PAUSED->RUN SHALL occur when count<=thr_low_r; pause_fifos[i] falls and continue_fifos[i] pulses high for exactly one cycle on the same edge.
REQ-027 A count between the two watermarks SHALL hold the current FSM state.
REQ-028 While set_init=1: push and pop SHALL be ignored, counts and sticky errors SHALL hold, all FSMs SHALL be forced to RUN, and pause_fifos and continue_fifos SHALL be 0 (no pulse on the forced exit from PAUSED).
REQ-029 While set_init=1, thresholds SHALL be loaded each cycle when thr_low<thr_high and thr_high<=DEPTH, clearing cfg_err.
REQ-030 While set_init=1 with invalid thresholds, the old values SHALL be kept and cfg_err set to 1.
REQ-031 Sticky errors SHALL clear only on reset.
REQ-032 Simultaneous events on different FIFOs SHALL be processed independently in the same cycle.

Reset
REQ-033 With reset_L=0 at a CLK edge, the block SHALL enter this state: counts 0, empty=4'hF, full=0, all FSMs RUN, pause_fifos=0, continue_fifos=0, err_ovf=0, err_udf=0, cfg_err=0, thr_high_r=6, thr_low_r=2 (DEPTH=8).
REQ-034 Reset asserted mid-operation SHALL take priority over all inputs, including set_init, and SHALL drop any in-flight pulse.

Verification
REQ-035 Reset, then push[0] for 6 cycles -> occupancy0=6; pause_fifos=4'b0001 one cycle later; empty=4'b1110.
REQ-036 From PAUSED at 6, pop[0] for 4 cycles -> count reaches 2; continue_fifos=4'b0001 for exactly one cycle; pause_fifos=0.
REQ-037 push[1] for 9 cycles -> count saturates at 8; full[1]=1; err_ovf[1]=1 and stays set; a subsequent push[1]+pop[1] -> count 8, no further change.
REQ-038 From empty, pop[2] alone -> err_udf[2]=1; push[2]+pop[2] together -> count=1.
REQ-039 set_init=1 with thr_high=3, thr_low=3 -> cfg_err=1 and thresholds stay 6/2; then thr_high=4, thr_low=1 -> cfg_err=0; after set_init drops, 4 pushes -> pause asserts.
REQ-040 FIFO3 PAUSED, then set_init=1 -> pause_fifos[3]=0, no continue pulse, and push/pop ignored.

Source files
------------

// File: rtl/fifo_level_monitor.sv
// Occupancy tracker for four FIFOs with per-FIFO RUN/PAUSED hysteresis, sticky
// overflow/underflow flags and a shared, runtime-configurable watermark pair.
module fifo_level_monitor #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic            CLK,
    input  logic            reset_L,
    input  logic            set_init,
    input  logic [CW-1:0]   thr_high,
    input  logic [CW-1:0]   thr_low,
    input  logic [3:0]      push,
    input  logic [3:0]      pop,
    output logic [4*CW-1:0] occupancy,
    output logic [3:0]      empty,
    output logic [3:0]      full,
    output logic [3:0]      pause_fifos,
    output logic [3:0]      continue_fifos,
    output logic [3:0]      err_ovf,
    output logic [3:0]      err_udf,
    output logic            cfg_err
);

    localparam logic [CW-1:0] DEPTH_C        = CW'(DEPTH);
    localparam logic [CW-1:0] THR_HIGH_RST_C = CW'((DEPTH * 3) / 4);
    localparam logic [CW-1:0] THR_LOW_RST_C  = CW'(DEPTH / 4);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    logic [CW-1:0] count_q [4];
    logic [CW-1:0] count_d [4];
    state_t        state_q [4];
    state_t        state_d [4];
    logic [3:0]    cont_q, cont_d;
    logic [3:0]    ovf_q, ovf_d;
    logic [3:0]    udf_q, udf_d;
    logic [CW-1:0] thr_high_q, thr_high_d;
    logic [CW-1:0] thr_low_q, thr_low_d;
    logic          cfg_err_q, cfg_err_d;
    logic          thr_valid;

    always_comb begin
        thr_valid  = (thr_low < thr_high) && (thr_high <= DEPTH_C);
        thr_high_d = thr_high_q;
        thr_low_d  = thr_low_q;
        cfg_err_d  = cfg_err_q;
        if (set_init) begin
            if (thr_valid) begin
                thr_high_d = thr_high;
                thr_low_d  = thr_low;
                cfg_err_d  = 1'b0;
            end else begin
                cfg_err_d  = 1'b1;
            end
        end
    end

    // A simultaneous push+pop on an empty FIFO still lands one entry, but the
    // pop had nothing to read, so it is flagged as an underflow.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            count_d[i] = count_q[i];
            ovf_d[i]   = ovf_q[i];
            udf_d[i]   = udf_q[i];
            if (!set_init) begin
                case ({push[i], pop[i]})
                    2'b10: begin
                        if (count_q[i] < DEPTH_C) count_d[i] = count_q[i] + CW'(1);
                        else                      ovf_d[i]   = 1'b1;
                    end
                    2'b01: begin
                        if (count_q[i] != '0) count_d[i] = count_q[i] - CW'(1);
                        else                  udf_d[i]   = 1'b1;
                    end
                    2'b11: begin
                        if (count_q[i] == '0) begin
                            count_d[i] = CW'(1);
                            udf_d[i]   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cont_d[i]  = 1'b0;
            if (set_init) begin
                state_d[i] = ST_RUN;
            end else begin
                case (state_q[i])
                    ST_RUN: begin
                        if (count_q[i] >= thr_high_q) state_d[i] = ST_PAUSED;
                    end
                    ST_PAUSED: begin
                        if (count_q[i] <= thr_low_q) begin
                            state_d[i] = ST_RUN;
                            cont_d[i]  = 1'b1;
                        end
                    end
                    default: state_d[i] = ST_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= '0;
                state_q[i] <= ST_RUN;
            end
            cont_q     <= '0;
            ovf_q      <= '0;
            udf_q      <= '0;
            thr_high_q <= THR_HIGH_RST_C;
            thr_low_q  <= THR_LOW_RST_C;
            cfg_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= count_d[i];
                state_q[i] <= state_d[i];
            end
            cont_q     <= cont_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            thr_high_q <= thr_high_d;
            thr_low_q  <= thr_low_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Flow-control outputs are masked by set_init so the configuration window
    // silences them immediately, not only after the forcing edge.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < 4; i++) begin
            occupancy[i*CW +: CW] = count_q[i];
            empty[i]              = (count_q[i] == '0);
            full[i]               = (count_q[i] == DEPTH_C);
            pause_fifos[i]        = (state_q[i] == ST_PAUSED) && !set_init;
        end
        continue_fifos = cont_q & {4{~set_init}};
        err_ovf        = ovf_q;
        err_udf        = udf_q;
        cfg_err        = cfg_err_q;
    end

endmodule

// File: tb/tb_fifo_level_monitor.sv
// Self-checking bench for fifo_level_monitor: directed scenarios plus random
// traffic, compared every cycle against an integer-level reference model.
module tb_fifo_level_monitor;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic            CLK = 1'b0;
    logic            reset_L;
    logic            set_init;
    logic [CW-1:0]   thr_high;
    logic [CW-1:0]   thr_low;
    logic [3:0]      push;
    logic [3:0]      pop;
    logic [4*CW-1:0] occupancy;
    logic [3:0]      empty;
    logic [3:0]      full;
    logic [3:0]      pause_fifos;
    logic [3:0]      continue_fifos;
    logic [3:0]      err_ovf;
    logic [3:0]      err_udf;
    logic            cfg_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state, kept as plain integers and flags
    int m_cnt    [4];
    bit m_paused [4];
    bit m_cont   [4];
    bit m_ovf    [4];
    bit m_udf    [4];
    int m_thh;
    int m_thl;
    bit m_cfgerr;

    fifo_level_monitor #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK            (CLK),
        .reset_L        (reset_L),
        .set_init       (set_init),
        .thr_high       (thr_high),
        .thr_low        (thr_low),
        .push           (push),
        .pop            (pop),
        .occupancy      (occupancy),
        .empty          (empty),
        .full           (full),
        .pause_fifos    (pause_fifos),
        .continue_fifos (continue_fifos),
        .err_ovf        (err_ovf),
        .err_udf        (err_udf),
        .cfg_err        (cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelEdge();
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0; m_paused[i] = 0; m_cont[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
            end
            m_thh = 6; m_thl = 2; m_cfgerr = 0;
        end else if (set_init) begin
            for (int i = 0; i < 4; i++) begin
                m_paused[i] = 0; m_cont[i] = 0;
            end
            if (int'(thr_low) < int'(thr_high) && int'(thr_high) <= DEPTH) begin
                m_thh = int'(thr_high); m_thl = int'(thr_low); m_cfgerr = 0;
            end else begin
                m_cfgerr = 1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                int old;
                old = m_cnt[i];
                m_cont[i] = 0;
                if (m_paused[i] && old <= m_thl) begin
                    m_paused[i] = 0; m_cont[i] = 1;
                end else if (!m_paused[i] && old >= m_thh) begin
                    m_paused[i] = 1;
                end
                if (push[i] && !pop[i]) begin
                    if (old < DEPTH) m_cnt[i] = old + 1; else m_ovf[i] = 1;
                end else if (pop[i] && !push[i]) begin
                    if (old > 0) m_cnt[i] = old - 1; else m_udf[i] = 1;
                end else if (push[i] && pop[i] && old == 0) begin
                    m_cnt[i] = 1; m_udf[i] = 1;
                end
            end
        end
    endtask

    task automatic compareModel();
        logic [4*CW-1:0] e_occ;
        logic [3:0] e_empty, e_full, e_pause, e_cont, e_ovf, e_udf;
        for (int i = 0; i < 4; i++) begin
            e_occ[i*CW +: CW] = CW'(m_cnt[i]);
            e_empty[i] = (m_cnt[i] == 0);
            e_full[i]  = (m_cnt[i] == DEPTH);
            e_pause[i] = m_paused[i] && !set_init;
            e_cont[i]  = m_cont[i] && !set_init;
            e_ovf[i]   = m_ovf[i];
            e_udf[i]   = m_udf[i];
        end
        checkOutput("occupancy", 64'(occupancy), 64'(e_occ));
        checkOutput("empty", 64'(empty), 64'(e_empty));
        checkOutput("full", 64'(full), 64'(e_full));
        checkOutput("pause_fifos", 64'(pause_fifos), 64'(e_pause));
        checkOutput("continue_fifos", 64'(continue_fifos), 64'(e_cont));
        checkOutput("err_ovf", 64'(err_ovf), 64'(e_ovf));
        checkOutput("err_udf", 64'(err_udf), 64'(e_udf));
        checkOutput("cfg_err", 64'(cfg_err), 64'(m_cfgerr));
    endtask

    // Apply one cycle of inputs, clock it, update the model and compare.
    task automatic applyStimulus(input logic rl, input logic si, input logic [CW-1:0] th,
                                 input logic [CW-1:0] tl, input logic [3:0] pu, input logic [3:0] po);
        reset_L  = rl;
        set_init = si;
        thr_high = th;
        thr_low  = tl;
        push     = pu;
        pop      = po;
        @(posedge CLK);
        modelEdge();
        #1;
        compareModel();
    endtask

    initial begin
        reset_L = 1'b0; set_init = 1'b0; thr_high = '0; thr_low = '0; push = '0; pop = '0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_paused[i] = 0; m_cont[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
        end
        m_thh = 6; m_thl = 2; m_cfgerr = 0;
        @(negedge CLK);

        applyStimulus(0, 0, 0, 0, 4'h0, 4'h0);
        applyStimulus(0, 0, 0, 0, 4'h0, 4'h0);
        checkOutput("rst_occ", 64'(occupancy), 64'h0);
        checkOutput("rst_empty", 64'(empty), 64'hF);
        checkOutput("rst_pause", 64'(pause_fifos), 64'h0);

        // Fill FIFO0 to the default high watermark
        for (int k = 0; k < 6; k++) applyStimulus(1, 0, 0, 0, 4'b0001, 4'b0000);
        checkOutput("fill_occ0", 64'(occupancy[CW-1:0]), 64'd6);
        checkOutput("fill_pause_lag", 64'(pause_fifos), 64'h0);
        applyStimulus(1, 0, 0, 0, 4'h0, 4'h0);
        checkOutput("fill_pause", 64'(pause_fifos), 64'b0001);
        checkOutput("fill_empty", 64'(empty), 64'b1110);

        // Drain FIFO0 to the low watermark and catch the resume pulse
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0001);
        checkOutput("drain_occ0", 64'(occupancy[CW-1:0]), 64'd2);
        applyStimulus(1, 0, 0, 0, 4'h0, 4'h0);
        checkOutput("drain_cont", 64'(continue_fifos), 64'b0001);
        checkOutput("drain_pause", 64'(pause_fifos), 64'h0);
        applyStimulus(1, 0, 0, 0, 4'h0, 4'h0);
        checkOutput("drain_cont_off", 64'(continue_fifos), 64'h0);

        // Overflow FIFO1
        for (int k = 0; k < 9; k++) applyStimulus(1, 0, 0, 0, 4'b0010, 4'b0000);
        checkOutput("ovf_occ1", 64'(occupancy[2*CW-1:CW]), 64'd8);
        checkOutput("ovf_full1", 64'(full[1]), 64'd1);
        checkOutput("ovf_flag", 64'(err_ovf), 64'b0010);
        applyStimulus(1, 0, 0, 0, 4'b0010, 4'b0010);
        checkOutput("ovf_pp_occ1", 64'(occupancy[2*CW-1:CW]), 64'd8);
        checkOutput("ovf_sticky", 64'(err_ovf), 64'b0010);

        // Underflow FIFO2, then push+pop on empty
        applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0100);
        checkOutput("udf_flag", 64'(err_udf), 64'b0100);
        applyStimulus(1, 0, 0, 0, 4'b0100, 4'b0100);
        checkOutput("udf_pp_occ2", 64'(occupancy[3*CW-1:2*CW]), 64'd1);

        // Rejected thresholds must leave 6/2 in force
        applyStimulus(1, 1, 4'd3, 4'd3, 4'h0, 4'h0);
        checkOutput("cfg_reject", 64'(cfg_err), 64'd1);
        applyStimulus(1, 0, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 4'b1000, 4'b0000);
        applyStimulus(1, 0, 0, 0, 4'h0, 4'h0);
        checkOutput("cfg_kept_thr", 64'(pause_fifos[3]), 64'd0);

        applyStimulus(1, 1, 4'd4, 4'd1, 4'h0, 4'h0);
        checkOutput("cfg_accept", 64'(cfg_err), 64'd0);
        applyStimulus(1, 0, 0, 0, 4'h0, 4'h0);
        checkOutput("cfg_new_pause", 64'(pause_fifos[3]), 64'd1);

        // set_init while FIFO3 is paused: silent exit and strobes ignored
        applyStimulus(1, 1, 4'd4, 4'd1, 4'b1000, 4'b0000);
        checkOutput("init_pause3", 64'(pause_fifos[3]), 64'd0);
        checkOutput("init_occ3", 64'(occupancy[4*CW-1:3*CW]), 64'd4);
        applyStimulus(1, 1, 4'd4, 4'd1, 4'b0000, 4'b1000);
        checkOutput("init_cont", 64'(continue_fifos), 64'h0);
        applyStimulus(1, 0, 0, 0, 4'h0, 4'h0);
        checkOutput("init_exit_cont", 64'(continue_fifos), 64'h0);

        // Random traffic with occasional configuration windows and resets
        for (int k = 0; k < 600; k++) begin
            logic rl, si;
            rl = ($urandom_range(0, 63) != 0);
            si = ($urandom_range(0, 15) == 0);
            applyStimulus(rl, si, CW'($urandom_range(0, 15)), CW'($urandom_range(0, 15)),
                          4'($urandom), 4'($urandom));
        end

        // Reset outranks set_init and strobes
        applyStimulus(0, 1, 4'd3, 4'd3, 4'hF, 4'h0);
        checkOutput("midrst_occ", 64'(occupancy), 64'h0);
        checkOutput("midrst_cfg", 64'(cfg_err), 64'd0);
        applyStimulus(1, 0, 0, 0, 4'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
